// File: rtl/regfile_clearable.sv
// -----------------------------------------------------------------------------
// regfile_clearable
//   Register file with NREGS = 2**ADDR_BITS entries. It has two combinational
//   read ports and one valid/ready write port. Entry 0 always reads as zero.
//   A clear sequencer zeroes entries 1..NREGS-1, one entry per cycle, when
//   clear_req is seen in IDLE. The write port is stalled (wr_ready=0) while a
//   clear is running.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous reset, active low (zeroes all entries)
//   wr_valid   in   write request valid
//   wr_ready   out  write port can accept (IDLE only)
//   wr_addr    in   write address (writes to 0 are accepted and dropped)
//   wr_data    in   write data
//   rd_addr1   in   read port 1 address
//   rd_data1   out  read port 1 data
//   rd_addr2   in   read port 2 address
//   rd_data2   out  read port 2 data
//   clear_req  in   start a clear sequence (level, sampled only in IDLE)
//   busy       out  clear sequence in progress
//
// Configuration
//   REGFILE_BYPASS_EN : when defined, a write being accepted this cycle is
//                       forwarded to any read port that addresses the same
//                       non-zero entry. When undefined, reads show the value
//                       stored before the write edge.
// -----------------------------------------------------------------------------
module regfile_clearable #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic [ADDR_BITS-1:0] rd_addr1,
  output logic [WIDTH-1:0]     rd_data1,
  input  logic [ADDR_BITS-1:0] rd_addr2,
  output logic [WIDTH-1:0]     rd_data2,
  input  logic                 clear_req,
  output logic                 busy
);

  localparam int NREGS = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] IDX_ONE  = {{(ADDR_BITS-1){1'b0}}, 1'b1};
  localparam logic [ADDR_BITS-1:0] IDX_LAST = {ADDR_BITS{1'b1}};
  localparam logic [ADDR_BITS-1:0] IDX_ZERO = {ADDR_BITS{1'b0}};
  localparam logic [WIDTH-1:0]     DATA_ZERO = {WIDTH{1'b0}};

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     mem_q [NREGS];
  logic                 wr_fire_s;

  // A write is accepted only when the port is ready and reset is released.
  assign wr_fire_s = wr_valid && wr_ready && rst_n;

  // State and clear-counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= IDX_ONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter logic. The counter starts at 1 because entry 0
  // is never stored; leaving CLEAR at the last entry avoids counter wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = IDX_ONE;
        end else begin
          state_d = IDLE;
          cnt_d   = cnt_q;
        end
      end
      CLEAR: begin
        if (cnt_q == IDX_LAST) begin
          state_d = IDLE;
          cnt_d   = IDX_ONE;
        end else begin
          state_d = CLEAR;
          cnt_d   = cnt_q + IDX_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = IDX_ONE;
      end
    endcase
  end

  // Handshake and status outputs decoded from the state register.
  always_comb begin
    wr_ready = 1'b0;
    busy     = 1'b0;
    case (state_q)
      IDLE: begin
        wr_ready = 1'b1;
        busy     = 1'b0;
      end
      CLEAR: begin
        wr_ready = 1'b0;
        busy     = 1'b1;
      end
      default: begin
        wr_ready = 1'b0;
        busy     = 1'b0;
      end
    endcase
  end

  // Storage: reset zeroes everything, CLEAR zeroes one entry per cycle,
  // IDLE commits accepted writes (address 0 is dropped).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= DATA_ZERO;
      end
    end else if (state_q == CLEAR) begin
      mem_q[cnt_q] <= DATA_ZERO;
    end else if (wr_fire_s && (wr_addr != IDX_ZERO)) begin
      mem_q[wr_addr] <= wr_data;
    end else begin
      mem_q[0] <= DATA_ZERO;
    end
  end

  // Combinational read ports; entry 0 is forced to zero.
  always_comb begin
`ifdef REGFILE_BYPASS_EN
    // wr_fire_s is never set in CLEAR, so no forwarding happens there.
    rd_data1 = (rd_addr1 == IDX_ZERO) ? DATA_ZERO :
               (wr_fire_s && (rd_addr1 == wr_addr)) ? wr_data : mem_q[rd_addr1];
    rd_data2 = (rd_addr2 == IDX_ZERO) ? DATA_ZERO :
               (wr_fire_s && (rd_addr2 == wr_addr)) ? wr_data : mem_q[rd_addr2];
`else
    rd_data1 = (rd_addr1 == IDX_ZERO) ? DATA_ZERO : mem_q[rd_addr1];
    rd_data2 = (rd_addr2 == IDX_ZERO) ? DATA_ZERO : mem_q[rd_addr2];
`endif
  end

endmodule
